// File: rtl/text_console_ctrl_pkg.sv
// Shared constants, control codes and FSM state encoding for the text console
// write sequencer.
package text_console_ctrl_pkg;

    localparam int COLS  = 40;
    localparam int ROWS  = 15;
    localparam int CELLS = COLS * ROWS;

    localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
    localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
    localparam logic [9:0] LAST_CELL = 10'(CELLS - 1);

    localparam logic [6:0] BLANK = 7'h20;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLR_ROW = 2'd1,
        ST_CLR_SCR = 2'd2,
        ST_CLR_ALL = 2'd3
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Byte input handshake plus text-buffer write port of the console sequencer.
interface text_console_ctrl_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        buffer_write_enable;
    logic [11:0] position;
    logic [6:0]  char_code;

    modport master (
        output in_valid, in_data,
        input  in_ready, buffer_write_enable, position, char_code
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, buffer_write_enable, position, char_code
    );

endinterface

// File: rtl/text_pos_calc.sv
// Combinational (row, col) -> linear buffer address; row*40 built from shifts.
module text_pos_calc (
    input  logic [3:0]  row,
    input  logic [5:0]  col,
    output logic [11:0] position
);

    assign position = {3'b000, row, 5'b00000}
                    + {5'b00000, row, 3'b000}
                    + {6'b000000, col};

endmodule

// File: rtl/text_console_ctrl.sv
// Text console write sequencer: cursor tracking, control-code handling and the
// power-up / row / full-screen clear sequences into the text buffer.
module text_console_ctrl
    import text_console_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    text_console_ctrl_if.slave  bus,
    output logic [3:0]          cursor_row,
    output logic [5:0]          cursor_col,
    output logic                busy
);

    state_t      state, state_nx;
    logic [3:0]  row_nx;
    logic [5:0]  col_nx;
    logic [9:0]  cnt, cnt_nx;
    logic        we, we_nx;
    logic [11:0] pos, pos_nx;
    logic [6:0]  code, code_nx;

    logic [3:0]  calc_row;
    logic [5:0]  calc_col;
    logic [11:0] calc_pos;
    logic [3:0]  row_adv;

    assign bus.in_ready            = (state == ST_IDLE);
    assign busy                    = (state != ST_IDLE);
    assign bus.buffer_write_enable = we;
    assign bus.position            = pos;
    assign bus.char_code           = code;

    assign row_adv = (cursor_row == LAST_ROW) ? 4'd0 : cursor_row + 4'd1;

    // The single address calculator serves the char write, the BS target cell
    // and the row being cleared.
    always_comb begin
        calc_row = cursor_row;
        calc_col = cursor_col;
        if (state == ST_CLR_ROW)
            calc_col = cnt[5:0];
        else if (bus.in_data == CH_BS)
            calc_col = cursor_col - 6'd1;
    end

    text_pos_calc u_pos_calc (
        .row      (calc_row),
        .col      (calc_col),
        .position (calc_pos)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch.
        state_nx = state;
        row_nx   = cursor_row;
        col_nx   = cursor_col;
        cnt_nx   = cnt;
        we_nx    = 1'b0;
        pos_nx   = pos;
        code_nx  = code;

        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (is_printable(bus.in_data)) begin
                        we_nx   = 1'b1;
                        pos_nx  = calc_pos;
                        code_nx = bus.in_data[6:0];
                        if (cursor_col == LAST_COL) begin
                            col_nx   = 6'd0;
                            row_nx   = row_adv;
                            cnt_nx   = 10'd0;
                            state_nx = ST_CLR_ROW;
                        end else begin
                            col_nx = cursor_col + 6'd1;
                        end
                    end else begin
                        case (bus.in_data)
                            CH_LF: begin
                                col_nx   = 6'd0;
                                row_nx   = row_adv;
                                cnt_nx   = 10'd0;
                                state_nx = ST_CLR_ROW;
                            end
                            CH_CR: col_nx = 6'd0;
                            CH_BS: begin
                                if (cursor_col != 6'd0) begin
                                    col_nx  = cursor_col - 6'd1;
                                    we_nx   = 1'b1;
                                    pos_nx  = calc_pos;
                                    code_nx = BLANK;
                                end
                            end
                            CH_FF: begin
                                cnt_nx   = 10'd0;
                                state_nx = ST_CLR_SCR;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_CLR_ROW: begin
                we_nx   = 1'b1;
                pos_nx  = calc_pos;
                code_nx = BLANK;
                cnt_nx  = cnt + 10'd1;
                if (cnt == {4'b0000, LAST_COL}) begin
                    cnt_nx   = 10'd0;
                    state_nx = ST_IDLE;
                end
            end

            ST_CLR_SCR, ST_CLR_ALL: begin
                we_nx   = 1'b1;
                pos_nx  = {2'b00, cnt};
                code_nx = BLANK;
                cnt_nx  = cnt + 10'd1;
                if (cnt == LAST_CELL) begin
                    cnt_nx   = 10'd0;
                    state_nx = ST_IDLE;
                    // Only a form feed homes the cursor once the screen is blank.
                    if (state == ST_CLR_SCR) begin
                        row_nx = 4'd0;
                        col_nx = 6'd0;
                    end
                end
            end

            default: state_nx = ST_CLR_ALL;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= ST_CLR_ALL;
            cursor_row <= 4'd0;
            cursor_col <= 6'd0;
            cnt        <= 10'd0;
            we         <= 1'b0;
            pos        <= 12'd0;
            code       <= 7'd0;
        end else begin
            state      <= state_nx;
            cursor_row <= row_nx;
            cursor_col <= col_nx;
            cnt        <= cnt_nx;
            we         <= we_nx;
            pos        <= pos_nx;
            code       <= code_nx;
        end
    end

endmodule
